// File: rtl/func_call_responder_pkg.sv
// ---------------------------------------------------------------------------
// func_call_pkg
//
// Shared definitions for the function-call responder:
//   FUNC_W           width of the function selector
//   FN_IDENT/FN_INV/FN_INC/FN_POPCNT  function selector encodings
//   state_e          responder FSM state encoding (IDLE/EXEC/RESP)
// ---------------------------------------------------------------------------
package func_call_pkg;

    localparam int FUNC_W = 2;

    localparam logic [FUNC_W-1:0] FN_IDENT  = 2'd0;
    localparam logic [FUNC_W-1:0] FN_INV    = 2'd1;
    localparam logic [FUNC_W-1:0] FN_INC    = 2'd2;
    localparam logic [FUNC_W-1:0] FN_POPCNT = 2'd3;

    // IDLE is the all-zero encoding so a reset state register lands in IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : func_call_pkg

// File: rtl/func_call_responder_if.sv
// ---------------------------------------------------------------------------
// func_call_responder_if
//
// Request/response channel between a caller and the responder.
//   req_valid/req_ready   request handshake (caller -> responder)
//   req_func              function selector
//   req_tag               caller tag, echoed back on resp_tag
//   req_arg               argument
//   resp_valid/resp_ready response handshake (responder -> caller)
//   resp_tag/resp_data    tag and result of the call being answered
//
// Modports: master = caller side, slave = responder side.
// ---------------------------------------------------------------------------
interface func_call_responder_if #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4
);

    logic                                 req_valid;
    logic                                 req_ready;
    logic [func_call_pkg::FUNC_W-1:0]     req_func;
    logic [TAG_W-1:0]                     req_tag;
    logic [DATA_W-1:0]                    req_arg;
    logic                                 resp_valid;
    logic                                 resp_ready;
    logic [TAG_W-1:0]                     resp_tag;
    logic [DATA_W-1:0]                    resp_data;

    modport master (
        output req_valid,
        output req_func,
        output req_tag,
        output req_arg,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_tag,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_func,
        input  req_tag,
        input  req_arg,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_tag,
        output resp_data
    );

endinterface : func_call_responder_if

// File: rtl/func_call_responder_popcount.sv
// ---------------------------------------------------------------------------
// func_popcount_seq
//
// Serial population count, one argument bit per clock.
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   start_i  load arg_i and begin counting (one-cycle pulse)
//   arg_i    value whose 1 bits are counted
//   done_o   high for exactly the cycle that processes the last bit
//   count_o  final bit count, valid while done_o is high
//
// After start_i the block runs for DATA_W cycles. count_o already includes
// the bit being processed in the current cycle, so the caller can latch the
// final sum on the same edge that retires the last bit.
// ---------------------------------------------------------------------------
module func_popcount_seq #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] arg_i,
    output logic              done_o,
    output logic [DATA_W-1:0] count_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] acc_q,   acc_d;
    logic              busy_q,  busy_d;

    // Accumulator plus the bit currently at the bottom of the shift register.
    logic [DATA_W-1:0] sum_next;

    assign sum_next = acc_q + {{(DATA_W-1){1'b0}}, shift_q[0]};

    // Next-state logic: load on start, otherwise retire one bit per cycle
    // while busy; busy drops after the cycle where the counter reaches 0.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        if (start_i) begin
            shift_d = arg_i;
            cnt_d   = CNT_W'(DATA_W - 1);
            acc_d   = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            acc_d   = sum_next;
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
        end
    end

    assign done_o  = busy_q && (cnt_q == '0);
    assign count_o = sum_next;

endmodule : func_popcount_seq

// File: rtl/func_call_responder.sv
// ---------------------------------------------------------------------------
// func_call_responder
//
// Callee side of the function-call interface. Accepts one call at a time,
// evaluates the selected function and returns the result with the caller's
// tag over a valid/ready response channel.
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   bus           func_call_responder_if slave modport (request/response)
//   call_count_o  number of completed calls (response handshakes), wraps
//
// FN_IDENT/FN_INV/FN_INC are evaluated on the accepting edge and the block
// goes straight to RESP. FN_POPCNT is handed to func_popcount_seq and the
// block waits in EXEC for DATA_W cycles.
// ---------------------------------------------------------------------------
module func_call_responder
    import func_call_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    func_call_responder_if.slave  bus,
    output logic [15:0]           call_count_o
);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q,   tag_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [15:0]       count_q, count_d;

    logic              accept;
    logic              pc_start;
    logic              pc_done;
    logic [DATA_W-1:0] pc_count;

    // Result of the functions that complete in a single cycle.
    function automatic logic [DATA_W-1:0] single_result(
        input logic [FUNC_W-1:0] func,
        input logic [DATA_W-1:0] arg
    );
        logic [DATA_W-1:0] res;
        res = arg;
        case (func)
            FN_INV:  res = ~arg;
            FN_INC:  res = arg + DATA_W'(1);
            default: res = arg;
        endcase
        return res;
    endfunction

    func_popcount_seq #(
        .DATA_W (DATA_W)
    ) u_popcount (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (pc_start),
        .arg_i   (bus.req_arg),
        .done_o  (pc_done),
        .count_o (pc_count)
    );

    // ready_q is itself registered, so it stays low for the first cycle
    // after reset and acceptance never depends combinationally on anything
    // but the registered handshake state.
    assign accept = (state_q == IDLE) && ready_q && bus.req_valid;

    // FSM next state, captured tag/result, and completed-call counter.
    // ready/valid are registered copies of the next state so the outputs
    // come straight from flops.
    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        data_d   = data_q;
        count_d  = count_q;
        pc_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tag_d = bus.req_tag;
                    if (bus.req_func == FN_POPCNT) begin
                        pc_start = 1'b1;
                        state_d  = EXEC;
                    end else begin
                        data_d  = single_result(bus.req_func, bus.req_arg);
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                if (pc_done) begin
                    data_d  = pc_count;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_tag   = tag_q;
    assign bus.resp_data  = data_q;
    assign call_count_o   = count_q;

endmodule : func_call_responder
